// File: rtl/imm_extend_arbiter.sv
// imm_extend_arbiter: two-requester round-robin arbiter in front of one shared immediate-extend unit
//
// Ports:
//    clk          rising-edge clock for all state
//    rst_n        synchronous active-low reset
//    req0_i       requester 0 (scalar decode) wants an extension, held with instr0_i until gnt0_o
//    instr0_i     requester 0 immediate field
//    req1_i       requester 1 (vector decode) wants an extension, held with instr1_i until gnt1_o
//    instr1_i     requester 1 immediate field
//    gnt0_o       one-cycle pulse: requester 0's field captured
//    gnt1_o       one-cycle pulse: requester 1's field captured
//    ext_instr_o  registered field driven to the shared extend unit
//    ext_imm_i    combinational result from the shared extend unit
//    out_valid_o  out_imm_o/out_id_o hold a result
//    out_ready_i  consumer accepts the result while out_valid_o is high
//    out_imm_o    captured extended immediate
//    out_id_o     requester index owning out_imm_o
//    busy_o       high whenever the arbiter is not idle
module imm_extend_arbiter #(
   parameter int INSTR_W = 7,
   parameter int IMM_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_i,
   input  logic [INSTR_W-1:0] instr0_i,
   input  logic               req1_i,
   input  logic [INSTR_W-1:0] instr1_i,
   output logic               gnt0_o,
   output logic               gnt1_o,
   output logic [INSTR_W-1:0] ext_instr_o,
   input  logic [IMM_W-1:0]   ext_imm_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [IMM_W-1:0]   out_imm_o,
   output logic               out_id_o,
   output logic               busy_o
);
   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
   state_t             state_q, state_d;
   logic               rr_q, rr_d;
   logic               gnt0_q, gnt0_d;
   logic               gnt1_q, gnt1_d;
   logic               out_valid_q, out_valid_d;
   logic               out_id_q, out_id_d;
   logic               busy_q, busy_d;
   logic [INSTR_W-1:0] ext_instr_q, ext_instr_d;
   logic [IMM_W-1:0]   out_imm_q, out_imm_d;
   logic               win;
   // contention is resolved by the pointer, otherwise the lone requester wins
   assign win = (req0_i & req1_i) ? rr_q : req1_i;
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      out_valid_d = out_valid_q;
      out_id_d    = out_id_q;
      ext_instr_d = ext_instr_q;
      out_imm_d   = out_imm_q;
      case (state_q)
         IDLE: if (req0_i | req1_i) begin
            state_d     = ISSUE;
            gnt0_d      = ~win;
            gnt1_d      = win;
            rr_d        = ~win;
            ext_instr_d = win ? instr1_i : instr0_i;
         end
         ISSUE: begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_imm_d   = ext_imm_i;
            // the pointer was set to the loser at grant time, so its complement is the owner
            out_id_d    = ~rr_q;
         end
         HOLD: if (out_ready_i) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_q        <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_id_q    <= 1'b0;
         busy_q      <= 1'b0;
         ext_instr_q <= '0;
         out_imm_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
         busy_q      <= busy_d;
         ext_instr_q <= ext_instr_d;
         out_imm_q   <= out_imm_d;
      end
   end
   assign gnt0_o      = gnt0_q;
   assign gnt1_o      = gnt1_q;
   assign ext_instr_o = ext_instr_q;
   assign out_valid_o = out_valid_q;
   assign out_imm_o   = out_imm_q;
   assign out_id_o    = out_id_q;
   assign busy_o      = busy_q;
endmodule

// File: tb/tb_imm_extend_arbiter.sv
// tb_imm_extend_arbiter: directed stimulus, transaction-level model compared every cycle, plus literal checks
module tb_imm_extend_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0, out_ready = 1'b0;
   logic [6:0]  instr0 = '0, instr1 = '0;
   logic        gnt0, gnt1, out_valid, out_id, busy;
   logic [6:0]  ext_instr;
   logic [15:0] ext_imm, out_imm;
   int          n_cmp = 0, n_bad = 0;
   bit          started = 1'b0, hold_mode = 1'b0;

   always #5 clk = ~clk;
   assign ext_imm = {9'b0, ext_instr};

   imm_extend_arbiter #(.INSTR_W(7), .IMM_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_i(req0), .instr0_i(instr0), .req1_i(req1), .instr1_i(instr1),
      .gnt0_o(gnt0), .gnt1_o(gnt1), .ext_instr_o(ext_instr), .ext_imm_i(ext_imm),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_imm_o(out_imm),
      .out_id_o(out_id), .busy_o(busy)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: m_age counts cycles since the last grant (0 = free, 1 = field at extend unit, 2 = result held)
   int          m_age = 0, m_who = 0, m_rr = 0, m_field = 0, m_imm = 0, m_id = 0, m_valid = 0;
   always @(posedge clk) begin
      started = 1'b1;
      if (!rst_n) begin
         m_age = 0; m_who = 0; m_rr = 0; m_field = 0; m_imm = 0; m_id = 0; m_valid = 0;
      end else if (m_age == 0) begin
         if (req0 || req1) begin
            m_who   = (req0 && req1) ? m_rr : (req1 ? 1 : 0);
            m_field = m_who == 1 ? int'(instr1) : int'(instr0);
            m_rr    = 1 - m_who;
            m_age   = 1;
         end
      end else if (m_age == 1) begin
         m_imm   = m_field % 65536;
         m_id    = m_who;
         m_valid = 1;
         m_age   = 2;
      end else if (out_ready) begin
         m_valid = 0;
         m_age   = 0;
      end
   end

   always @(negedge clk) if (started) begin
      chk("gnt0", gnt0, (m_age == 1 && m_who == 0) ? 1 : 0);
      chk("gnt1", gnt1, (m_age == 1 && m_who == 1) ? 1 : 0);
      chk("gnt_excl", gnt0 & gnt1, 0);
      chk("ext_instr", ext_instr, m_field);
      chk("out_valid", out_valid, m_valid);
      chk("out_imm", out_imm, m_imm);
      chk("out_id", out_id, m_id);
      chk("busy", busy, m_age != 0 ? 1 : 0);
   end

   // a requester drops its request once it sees its grant, unless held continuously
   task automatic step();
      @(negedge clk);
      if (!hold_mode) begin
         if (gnt0) req0 = 1'b0;
         if (gnt1) req1 = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0; hold_mode = 1'b0;
      step();
      step();
      chk("rst_valid", out_valid, 0);
      chk("rst_imm", out_imm, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ext", ext_instr, 0);
      chk("rst_gnt", {gnt0, gnt1}, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      int g0, g1, last, total;
      // single request with ready held high
      do_reset();
      req0 = 1'b1; instr0 = 7'b1010101; out_ready = 1'b1;
      step(); chk("t1_gnt0", gnt0, 1);
      step(); chk("t1_valid", out_valid, 1); chk("t1_imm", out_imm, 16'h0055); chk("t1_id", out_id, 0);
      step(); chk("t1_drop", out_valid, 0); chk("t1_busy", busy, 0);
      // simultaneous requests from reset
      do_reset();
      req0 = 1'b1; req1 = 1'b1; instr0 = 7'h0F; instr1 = 7'h01; out_ready = 1'b1;
      step(); chk("t2_g0", {gnt0, gnt1}, 2'b10);
      step(); chk("t2_imm0", out_imm, 16'h000F); chk("t2_id0", out_id, 0);
      step(); chk("t2_idle", out_valid, 0);
      step(); chk("t2_g1", {gnt0, gnt1}, 2'b01);
      step(); chk("t2_imm1", out_imm, 16'h0001); chk("t2_id1", out_id, 1);
      // backpressure holds the result and blocks the other requester
      do_reset();
      req0 = 1'b1; instr0 = 7'h33;
      step(); chk("t3_gnt0", gnt0, 1);
      req1 = 1'b1; instr1 = 7'h44;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t3_hold_valid", out_valid, 1); chk("t3_hold_imm", out_imm, 16'h0033);
         chk("t3_hold_busy", busy, 1); chk("t3_hold_gnt1", gnt1, 0);
      end
      out_ready = 1'b1;
      step(); chk("t3_drop", out_valid, 0); chk("t3_no_gnt1_yet", gnt1, 0);
      step(); chk("t3_gnt1", gnt1, 1); chk("t3_ext", ext_instr, 7'h44);
      step(); step();
      // reset while a result is held
      do_reset();
      req0 = 1'b1; instr0 = 7'h7F;
      step(); step(); chk("t4_valid", out_valid, 1); chk("t4_imm", out_imm, 16'h007F);
      rst_n = 1'b0;
      step(); chk("t4_valid0", out_valid, 0); chk("t4_busy0", busy, 0); chk("t4_imm0", out_imm, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(); chk("t4_stale", out_valid, 0);
      end
      // both requesters held continuously: strict alternation
      do_reset();
      hold_mode = 1'b1; req0 = 1'b1; req1 = 1'b1; instr0 = 7'h12; instr1 = 7'h65; out_ready = 1'b1;
      g0 = 0; g1 = 0; last = 1; total = 0;
      for (int k = 0; k < 60 && total < 10; k++) begin
         step();
         if (gnt0 || gnt1) begin
            chk("t5_alt", gnt1, 1 - last);
            last = gnt1 ? 1 : 0;
            if (gnt0) g0++; else g1++;
            total++;
         end
      end
      chk("t5_total", total, 10);
      chk("t5_g0", g0, 5);
      chk("t5_g1", g1, 5);
      hold_mode = 1'b0; req0 = 1'b0; req1 = 1'b0;
      step(); step(); step(); step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
